// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter.
// Holds the FSM state encodings and the data-bit count used by uart_tx.
// Optional feature macro: UART_TX_PARITY_EN adds the TX_PARITY_BIT state.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = 3;

  // Transmitter states, 3-bit encoding
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_DATA_BIT   = 3'd2,
    TX_STOP_BIT   = 3'd3
`ifdef UART_TX_PARITY_EN
    , TX_PARITY_BIT = 3'd4
`endif
  } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gapless
// back-to-back frames.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between data bit 7 and the stop bit.
// Ports:
//   i_Clk        clock, rising edge
//   i_Rst        synchronous active-high reset
//   i_TX_DV      byte-valid strobe, accepted only while o_TX_Ready=1
//   i_TX_Byte    byte to send, sampled on the accepting edge
//   o_TX_Ready   holding register empty
//   o_TX_Active  high from first start-bit cycle to last stop-bit cycle
//   o_TX_Serial  registered serial line, idle high
//   o_TX_Done    one-cycle pulse on the last cycle of each stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic                   ready_q, ready_d;
  logic                   serial_q, serial_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic                   accept;
  logic                   bit_end;
  logic                   take_direct;
  logic                   load_en;
  logic [DATA_BITS-1:0]   load_byte;

  // State register and datapath flops
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      hold_q   <= '0;
      ready_q  <= 1'b1;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      ready_q  <= ready_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    ready_d     = ready_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    accept      = i_TX_DV && ready_q;
    bit_end     = (cnt_q == CNT_LAST);
    take_direct = 1'b0;
    load_en     = 1'b0;
    load_byte   = hold_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          take_direct = 1'b1;
          load_en     = 1'b1;
          load_byte   = i_TX_Byte;
        end
      end
      TX_START_BIT: begin
        if (bit_end) state_d = TX_DATA_BIT;
      end
      TX_DATA_BIT: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY_BIT;
`else
            state_d = TX_STOP_BIT;
`endif
          end else begin
            idx_d   = idx_q + BIT_IDX_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: begin
        if (bit_end) state_d = TX_STOP_BIT;
      end
`endif
      TX_STOP_BIT: begin
        // Held byte wins; otherwise a same-cycle accept chains straight on
        if (bit_end) begin
          if (!ready_q) begin
            load_en   = 1'b1;
            load_byte = hold_q;
            ready_d   = 1'b1;
          end else if (accept) begin
            take_direct = 1'b1;
            load_en     = 1'b1;
            load_byte   = i_TX_Byte;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Bit-cycle counter restarts at every bit boundary, so it never wraps
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

    if (load_en) begin
      state_d  = TX_START_BIT;
      shift_d  = load_byte;
      cnt_d    = '0;
      idx_d    = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^load_byte;
`endif
    end

    if (accept && !take_direct) begin
      hold_d  = i_TX_Byte;
      ready_d = 1'b0;
    end

    // Outputs are registered, so derive them from the next state
    unique case (state_d)
      TX_START_BIT:  serial_d = 1'b0;
      TX_DATA_BIT:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: serial_d = parity_d;
`endif
      default:       serial_d = 1'b1;
    endcase
    active_d = (state_d != IDLE);
    done_d   = (state_d == TX_STOP_BIT) && (cnt_d == CNT_LAST);
  end

  assign o_TX_Ready  = ready_q;
  assign o_TX_Active = active_q;
  assign o_TX_Serial = serial_q;
  assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4.
// A frame-level reference model predicts every output cycle; a line
// decoder checks each received byte against the frames the model started.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS     = 11;
  localparam int FRAME_CYC = 44;
`else
  localparam int NBITS     = 10;
  localparam int FRAME_CYC = 40;
`endif
  localparam int FL = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] tbyte;
  logic       o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_TX_DV    (dv),
    .i_TX_Byte  (tbyte),
    .o_TX_Ready (o_TX_Ready),
    .o_TX_Active(o_TX_Active),
    .o_TX_Serial(o_TX_Serial),
    .o_TX_Done  (o_TX_Done)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Frame-level model: busy flag, position inside the frame, one pending byte
  bit         m_busy   = 1'b0;
  bit         m_pend_v = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = '0;
  logic [7:0] m_pend   = '0;
  int         rst_gen  = 0;
  logic [7:0] exp_q[$];

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit acc, took;
    if (rst) begin
      m_busy = 1'b0; m_pend_v = 1'b0; m_pos = 0;
      exp_q.delete();
      rst_gen++;
    end else begin
      acc  = dv && !m_pend_v;
      took = 1'b0;
      if (m_busy && m_pos == FL - 1) begin
        if (m_pend_v) begin
          m_cur = m_pend; m_pend_v = 1'b0; m_pos = 0; exp_q.push_back(m_cur);
        end else if (acc) begin
          m_cur = tbyte; took = 1'b1; m_pos = 0; exp_q.push_back(m_cur);
        end else begin
          m_busy = 1'b0;
        end
      end else if (m_busy) begin
        m_pos++;
      end else if (acc) begin
        m_busy = 1'b1; m_cur = tbyte; took = 1'b1; m_pos = 0; exp_q.push_back(m_cur);
      end
      if (acc && !took) begin
        m_pend = tbyte; m_pend_v = 1'b1;
      end
    end
  end

  // Line decoder state
  int          rx_t    = -1;
  logic [15:0] rx_bits = '0;
  logic        rx_prev = 1'b1;
  int          rst_seen = 0;
  logic [7:0]  rx_log[$];

  task automatic rx_frame();
    logic [7:0] b;
    b = rx_bits[8:1];
    chk("rx_start_bit", int'(rx_bits[0]), 0);
    chk("rx_stop_bit", int'(rx_bits[NBITS-1]), 1);
`ifdef UART_TX_PARITY_EN
    chk("rx_parity_bit", int'(rx_bits[9]), int'(^b));
`endif
    chk("rx_frame_expected", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) chk("rx_byte", int'(b), int'(exp_q.pop_front()));
    rx_log.push_back(b);
  endtask

  // Per-cycle compare against the model, plus line decoding
  always @(negedge clk) begin
    if (chk_en) begin
      chk("serial", int'(o_TX_Serial), int'(m_busy ? frame_bit(m_cur, m_pos / CPB) : 1'b1));
      chk("active", int'(o_TX_Active), int'(m_busy));
      chk("done",   int'(o_TX_Done),   int'(m_busy && m_pos == FL - 1));
      chk("ready",  int'(o_TX_Ready),  int'(!m_pend_v));
      if (rst_seen != rst_gen) begin
        rst_seen = rst_gen;
        rx_t = -1;
      end else begin
        if (rx_t < 0 && rx_prev && !o_TX_Serial) rx_t = 0;
        if (rx_t >= 0) begin
          if (rx_t % CPB == CPB / 2) rx_bits[rx_t / CPB] = o_TX_Serial;
          if (rx_t == (NBITS - 1) * CPB + CPB / 2) begin
            rx_frame();
            rx_t = -1;
          end else begin
            rx_t++;
          end
        end
      end
      rx_prev = o_TX_Serial;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((o_TX_Active || !o_TX_Ready) && n < 4 * FL) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_bound", int'(n < 4 * FL), 1);
    @(negedge clk);
  endtask

  // One frame from idle; line_exp[k] is the expected level of bit slot k
  task automatic run_single(input logic [7:0] b, input logic [15:0] line_exp, input string nm);
    int n_done = 0, done_at = 0, n_act = 0, hold_bad = 0;
    @(negedge clk); dv = 1'b1; tbyte = b;
    for (int c = 1; c <= FL + 6; c++) begin
      @(negedge clk); dv = 1'b0;
      if (o_TX_Done) begin n_done++; done_at = c; end
      if (o_TX_Active) n_act++;
      if (c <= FRAME_CYC && o_TX_Serial !== line_exp[(c - 1) / CPB]) hold_bad++;
    end
    chk({nm, "_line_levels"}, hold_bad, 0);
    chk({nm, "_done_count"}, n_done, 1);
    chk({nm, "_done_cycle"}, done_at, FRAME_CYC);
    chk({nm, "_active_cycles"}, n_act, FRAME_CYC);
  endtask

  // 0xA3 then 0x0F while busy; 0x99 and 0xC3 arrive while full and are dropped
  task automatic run_pair();
    int n_done = 0, n_act = 0, n_rdy_lo = 0, d1 = 0, d2 = 0, log0;
    log0 = rx_log.size();
    @(negedge clk); dv = 1'b1; tbyte = 8'hA3;
    for (int c = 1; c <= 2 * FL + 8; c++) begin
      @(negedge clk); dv = 1'b0;
      if (o_TX_Done) begin n_done++; if (n_done == 1) d1 = c; else d2 = c; end
      if (o_TX_Active) n_act++;
      if (!o_TX_Ready) n_rdy_lo++;
      if (c == 10) begin dv = 1'b1; tbyte = 8'h0F; end
      if (c == 20) begin dv = 1'b1; tbyte = 8'h99; end
      if (c == FL) begin dv = 1'b1; tbyte = 8'hC3; end
    end
    chk("pair_done_count", n_done, 2);
    chk("pair_done1_cycle", d1, FRAME_CYC);
    chk("pair_done2_cycle", d2, 2 * FRAME_CYC);
    chk("pair_active_cycles", n_act, 2 * FRAME_CYC);
    chk("pair_ready_low_cycles", n_rdy_lo, FRAME_CYC - 10);
    chk("pair_rx_frames", rx_log.size() - log0, 2);
    if (rx_log.size() - log0 == 2) begin
      chk("pair_rx_byte0", int'(rx_log[log0]), 8'hA3);
      chk("pair_rx_byte1", int'(rx_log[log0 + 1]), 8'h0F);
    end
  endtask

  // Reset at cycle 15 of a 0xFF frame with 0x3C held
  task automatic run_reset_abort();
    int n_done = 0, act_after = 0;
    @(negedge clk); dv = 1'b1; tbyte = 8'hFF;
    for (int c = 1; c <= FL + 10; c++) begin
      @(negedge clk); dv = 1'b0; rst = 1'b0;
      if (o_TX_Done) n_done++;
      if (c == 16) begin
        chk("abort_serial", int'(o_TX_Serial), 1);
        chk("abort_ready", int'(o_TX_Ready), 1);
        chk("abort_active", int'(o_TX_Active), 0);
      end
      if (c > 16 && o_TX_Active) act_after++;
      if (c == 5) begin dv = 1'b1; tbyte = 8'h3C; end
      if (c == 15) begin
        chk("abort_pre_ready", int'(o_TX_Ready), 0);
        rst = 1'b1;
      end
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_hold_cleared", act_after, 0);
  endtask

  task automatic send_when_ready(input logic [7:0] b);
    int n = 0;
    while (!o_TX_Ready && n < 4 * FL) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_bound", int'(n < 4 * FL), 1);
    dv = 1'b1; tbyte = b;
    @(negedge clk);
    dv = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] line55;
    logic [7:0]  lb [3];
    int          log0;
    lb = '{8'h00, 8'hFF, 8'h5A};
`ifdef UART_TX_PARITY_EN
    line55 = 16'h04AA;
`else
    line55 = 16'h02AA;
`endif

    // Reset with DV held high: DV must be ignored
    rst = 1'b1; dv = 1'b1; tbyte = 8'h12;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_serial", int'(o_TX_Serial), 1);
    chk("reset_ready",  int'(o_TX_Ready), 1);
    chk("reset_active", int'(o_TX_Active), 0);
    chk("reset_done",   int'(o_TX_Done), 0);
    rst = 1'b0; dv = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dv_ignored", int'(o_TX_Active), 0);

    run_single(8'h55, line55, "x55");
`ifdef UART_TX_PARITY_EN
    wait_idle();
    run_single(8'h07, 16'h060E, "x07");
`endif
    wait_idle();
    run_pair();
    wait_idle();
    run_reset_abort();
    wait_idle();

    // Loopback of three bytes through the line decoder
    log0 = rx_log.size();
    foreach (lb[i]) send_when_ready(lb[i]);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("loop_rx_frames", rx_log.size() - log0, 3);
    if (rx_log.size() - log0 == 3) begin
      foreach (lb[i]) chk("loop_rx_byte", int'(rx_log[log0 + i]), int'(lb[i]));
    end

    // Randomized traffic with occasional resets and idle gaps
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      dv    = ($urandom_range(0, 5) == 0);
      tbyte = 8'($urandom);
      rst   = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 299) == 0) begin
        dv = 1'b0; rst = 1'b0;
        repeat (60) @(negedge clk);
      end
    end
    @(negedge clk);
    dv = 1'b0; rst = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("random_frames_decoded", int'(rx_log.size() > 20), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
